// File: rtl/i2s_to_wb_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i2s_to_wb_tx_sequencer
// Brief    : Master-mode I2S transmitter. Generates sck/ws, pops stereo
//            frames from the TX FIFO and shifts them out MSB-first on sd.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_to_wb_tx_sequencer #(
    parameter int DW      = 16,
    parameter int CLK_DIV = 4
) (
    input  logic            i2s_clk_i,
    input  logic            i2s_rst_i,
    input  logic            enable_i,
    input  logic            fifo_empty_i,
    input  logic [2*DW-1:0] fifo_rd_data_i,
    output logic            fifo_pop_o,
    output logic            i2s_sck_o,
    output logic            i2s_ws_o,
    output logic            i2s_sd_o,
    output logic            underrun_o,
    output logic [15:0]     underrun_cnt_o,
    output logic            running_o
);

    localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_bit_w = $clog2(DW);
    localparam logic [c_div_w-1:0] c_div_max = c_div_w'(CLK_DIV - 1);
    localparam logic [c_bit_w-1:0] c_bit_max = c_bit_w'(DW - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_div_w-1:0] r_div_cnt;
    logic [c_bit_w-1:0] r_bit_cnt;
    logic [DW-1:0]      r_shreg;
    logic [DW-1:0]      r_right;
    logic [2*DW-1:0]    r_hold;
    logic               r_hold_valid;
    logic               r_sck;
    logic               r_ws;
    logic               r_sd;
    logic               r_underrun;
    logic [15:0]        r_underrun_cnt;

    logic w_tick;
    logic w_fall;
    logic w_boundary;
    logic w_left_load;
    logic w_stop;
    logic w_underrun;
    logic w_load_hold;

    assign w_tick      = (r_state == ST_RUN) && (r_div_cnt == c_div_max);
    assign w_fall      = w_tick && r_sck;
    assign w_boundary  = w_fall && (r_bit_cnt == c_bit_max);
    assign w_left_load = w_boundary && r_ws;
    assign w_stop      = w_left_load && !enable_i;
    assign w_underrun  = w_left_load && enable_i && !r_hold_valid;
    assign w_load_hold = w_left_load && enable_i && r_hold_valid;

    // Pop is withheld in the left-load cycle: that frame is already an underrun.
    assign fifo_pop_o = ((r_state == ST_START) || (r_state == ST_RUN)) &&
                        !r_hold_valid && !fifo_empty_i && !w_left_load;

    assign i2s_sck_o      = r_sck;
    assign i2s_ws_o       = r_ws;
    assign i2s_sd_o       = r_sd;
    assign underrun_o     = r_underrun;
    assign underrun_cnt_o = r_underrun_cnt;
    assign running_o      = (r_state == ST_RUN);

    always_ff @(posedge i2s_clk_i or posedge i2s_rst_i) begin
        if (i2s_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (enable_i) w_state_nxt = ST_START;
            ST_START: begin
                if (!enable_i)         w_state_nxt = ST_IDLE;
                else if (r_hold_valid) w_state_nxt = ST_RUN;
            end
            ST_RUN:   if (w_stop) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i2s_clk_i or posedge i2s_rst_i) begin
        if (i2s_rst_i) begin
            r_div_cnt      <= '0;
            r_bit_cnt      <= c_bit_max;
            r_shreg        <= '0;
            r_right        <= '0;
            r_hold         <= '0;
            r_hold_valid   <= 1'b0;
            r_sck          <= 1'b0;
            r_ws           <= 1'b1;
            r_sd           <= 1'b0;
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
        end else begin
            r_underrun <= w_underrun;
            if (w_underrun && (r_underrun_cnt != 16'hFFFF)) begin
                r_underrun_cnt <= r_underrun_cnt + 16'd1;
            end

            if (fifo_pop_o) begin
                r_hold       <= fifo_rd_data_i;
                r_hold_valid <= 1'b1;
            end else if (w_load_hold) begin
                r_hold_valid <= 1'b0;
            end

            case (r_state)
                ST_RUN: begin
                    if (w_tick) begin
                        r_div_cnt <= '0;
                        r_sck     <= ~r_sck;
                    end else begin
                        r_div_cnt <= r_div_cnt + c_div_w'(1);
                    end
                    if (w_fall) begin
                        r_sd      <= r_shreg[DW-1];
                        r_shreg   <= r_shreg << 1;
                        r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
                    end
                    // Word boundary: the LSB just went out, ws flips with it.
                    if (w_boundary) begin
                        r_bit_cnt <= '0;
                        if (!r_ws) begin
                            r_ws    <= 1'b1;
                            r_shreg <= r_right;
                        end else if (w_stop) begin
                            r_sd      <= 1'b0;
                            r_sck     <= 1'b0;
                            r_bit_cnt <= c_bit_max;
                        end else if (r_hold_valid) begin
                            r_ws    <= 1'b0;
                            r_shreg <= r_hold[2*DW-1:DW];
                            r_right <= r_hold[DW-1:0];
                        end else begin
                            r_ws    <= 1'b0;
                            r_shreg <= '0;
                            r_right <= '0;
                        end
                    end
                end
                default: begin
                    r_div_cnt <= '0;
                    r_bit_cnt <= c_bit_max;
                    r_sck     <= 1'b0;
                    r_ws      <= 1'b1;
                    r_sd      <= 1'b0;
                    if (w_state_nxt == ST_RUN) r_shreg <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_to_wb_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_to_wb_tx_sequencer
// Brief    : Directed self-checking bench for the I2S TX sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_to_wb_tx_sequencer;

    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic            fifo_empty = 1'b1;
    logic [2*DW-1:0] fifo_data = '0;
    logic            fifo_pop_o;
    logic            i2s_sck_o;
    logic            i2s_ws_o;
    logic            i2s_sd_o;
    logic            underrun_o;
    logic [15:0]     underrun_cnt_o;
    logic            running_o;

    i2s_to_wb_tx_sequencer #(.DW(DW), .CLK_DIV(2)) dut (
        .i2s_clk_i      (clk),
        .i2s_rst_i      (rst),
        .enable_i       (enable),
        .fifo_empty_i   (fifo_empty),
        .fifo_rd_data_i (fifo_data),
        .fifo_pop_o     (fifo_pop_o),
        .i2s_sck_o      (i2s_sck_o),
        .i2s_ws_o       (i2s_ws_o),
        .i2s_sd_o       (i2s_sd_o),
        .underrun_o     (underrun_o),
        .underrun_cnt_o (underrun_cnt_o),
        .running_o      (running_o)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_checks = 0;

    logic [2*DW-1:0] q[$];
    logic            pop_req = 1'b0;
    int              fall_cnt = 0;
    int              pop_cnt = 0;
    int              bad_pop = 0;
    int              und_cycles = 0;
    int              und_fall_idx = -1;
    int              cyc = 0;
    logic            prev_sck = 1'b0;
    logic            sd_log [0:2047];
    logic            ws_log [0:2047];
    int              cyc_log[0:2047];

    task automatic fifo_refresh();
        fifo_empty = (q.size() == 0);
        fifo_data  = (q.size() != 0) ? q[0] : '0;
    endtask

    task automatic push(input logic [2*DW-1:0] f);
        q.push_back(f);
        fifo_refresh();
    endtask

    always @(posedge clk) cyc++;

    // Line monitor: logs each sck falling edge and counts pops/underruns.
    always @(negedge clk) begin
        if (prev_sck && !i2s_sck_o && fall_cnt < 2047) begin
            fall_cnt++;
            sd_log[fall_cnt]  = i2s_sd_o;
            ws_log[fall_cnt]  = i2s_ws_o;
            cyc_log[fall_cnt] = cyc;
        end
        prev_sck = i2s_sck_o;
        if (fifo_pop_o) begin
            pop_cnt++;
            if (running_o && i2s_ws_o) bad_pop++;
            pop_req = 1'b1;
        end
        if (underrun_o) begin
            und_cycles++;
            und_fall_idx = fall_cnt;
        end
    end

    always @(posedge clk) begin
        #1;
        if (pop_req) begin
            if (q.size() != 0) void'(q.pop_front());
            pop_req = 1'b0;
            fifo_refresh();
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] word_at(input int first);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < DW; i++) w = {w[DW-2:0], sd_log[first+i]};
        return w;
    endfunction

    task automatic wait_fall(input int idx, input string tag);
        int n;
        n = 0;
        while (fall_cnt < idx && n < 4000) begin
            @(negedge clk); #1;
            n++;
        end
        check(tag, 32'(fall_cnt >= idx), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (running_o && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        check(tag, 32'(running_o), 32'd0);
    endtask

    int s, p0, u0;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_sck", 32'(i2s_sck_o), 32'd0);
        check("rst_ws", 32'(i2s_ws_o), 32'd1);
        check("rst_sd", 32'(i2s_sd_o), 32'd0);
        check("rst_underrun", 32'(underrun_o), 32'd0);
        check("rst_cnt", 32'(underrun_cnt_o), 32'd0);
        check("rst_running", 32'(running_o), 32'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        check("idle_pop", 32'(fifo_pop_o), 32'd0);

        // Four-frame stream, then stop mid-left word of the last frame
        push({16'hA5A5, 16'h0F0F});
        push({16'h1234, 16'h8001});
        push({16'hFFFF, 16'h0000});
        push({16'hC3C3, 16'h5A5A});
        s = fall_cnt + 1;
        enable = 1'b1;
        wait_fall(s + 104, "a_reach");
        enable = 1'b0;
        wait_idle("a_idle");
        check("a_first_sd", 32'(sd_log[s]), 32'd0);
        check("a_ws_fall1", 32'(ws_log[s]), 32'd0);
        check("a_sck_period", 32'(cyc_log[s+1] - cyc_log[s]), 32'd4);
        check("a_L0", 32'(word_at(s + 1)), 32'hA5A5);
        check("a_ws_fall17", 32'(ws_log[s+16]), 32'd1);
        check("a_R0", 32'(word_at(s + 17)), 32'h0F0F);
        check("a_L1", 32'(word_at(s + 33)), 32'h1234);
        check("a_R1", 32'(word_at(s + 49)), 32'h8001);
        check("a_L2", 32'(word_at(s + 65)), 32'hFFFF);
        check("a_R2", 32'(word_at(s + 81)), 32'h0000);
        check("a_L3", 32'(word_at(s + 97)), 32'hC3C3);
        check("a_R3", 32'(word_at(s + 113)), 32'h5A5A);
        check("a_pops", 32'(pop_cnt), 32'd4);
        check("a_bad_pops", 32'(bad_pop), 32'd0);
        check("a_no_underrun", 32'(und_cycles), 32'd0);
        check("a_stop_fall", 32'(fall_cnt), 32'(s + 128));
        check("a_stop_ws_log", 32'(ws_log[s+128]), 32'd1);
        check("a_stop_sck", 32'(i2s_sck_o), 32'd0);
        check("a_stop_ws", 32'(i2s_ws_o), 32'd1);
        check("a_stop_sd", 32'(i2s_sd_o), 32'd0);
        repeat (40) @(negedge clk);
        #1;
        check("a_no_more_pops", 32'(pop_cnt), 32'd4);
        check("a_no_more_falls", 32'(fall_cnt), 32'(s + 128));

        // Underrun on frame 2, refill mid-frame, frame 3 realigned
        p0 = pop_cnt;
        push({16'h1111, 16'h2222});
        s = fall_cnt + 1;
        enable = 1'b1;
        wait_fall(s + 40, "b_reach_refill");
        push({16'hBEEF, 16'hCAFE});
        wait_fall(s + 72, "b_reach_stop");
        enable = 1'b0;
        wait_idle("b_idle");
        check("b_L0", 32'(word_at(s + 1)), 32'h1111);
        check("b_R0", 32'(word_at(s + 17)), 32'h2222);
        check("b_L1_zero", 32'(word_at(s + 33)), 32'h0000);
        check("b_R1_zero", 32'(word_at(s + 49)), 32'h0000);
        check("b_L2", 32'(word_at(s + 65)), 32'hBEEF);
        check("b_R2", 32'(word_at(s + 81)), 32'hCAFE);
        check("b_und_cycles", 32'(und_cycles), 32'd1);
        check("b_und_at_left_load", 32'(und_fall_idx), 32'(s + 32));
        check("b_cnt", 32'(underrun_cnt_o), 32'd1);
        check("b_pops", 32'(pop_cnt - p0), 32'd2);

        // Asynchronous reset mid-word while sck is high
        push({16'hFFFF, 16'h5555});
        s = fall_cnt + 1;
        enable = 1'b1;
        wait_fall(s + 4, "c_reach");
        for (int i = 0; i < 20 && !i2s_sck_o; i++) begin
            @(negedge clk); #1;
        end
        check("c_pre_sck", 32'(i2s_sck_o), 32'd1);
        check("c_pre_ws", 32'(i2s_ws_o), 32'd0);
        check("c_pre_sd", 32'(i2s_sd_o), 32'd1);
        check("c_pre_cnt", 32'(underrun_cnt_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("c_rst_sck", 32'(i2s_sck_o), 32'd0);
        check("c_rst_ws", 32'(i2s_ws_o), 32'd1);
        check("c_rst_sd", 32'(i2s_sd_o), 32'd0);
        check("c_rst_cnt", 32'(underrun_cnt_o), 32'd0);
        check("c_rst_running", 32'(running_o), 32'd0);
        enable = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;

        // Clean restart after reset with a fresh pop
        p0 = pop_cnt;
        push({16'h9C9C, 16'h3C3C});
        s = fall_cnt + 1;
        enable = 1'b1;
        wait_fall(s + 8, "d_reach");
        enable = 1'b0;
        wait_idle("d_idle");
        check("d_pops", 32'(pop_cnt - p0), 32'd1);
        check("d_first_sd", 32'(sd_log[s]), 32'd0);
        check("d_L0", 32'(word_at(s + 1)), 32'h9C9C);
        check("d_R0", 32'(word_at(s + 17)), 32'h3C3C);
        check("d_cnt", 32'(underrun_cnt_o), 32'd0);

        // Saturation: preload the counter near full, then underrun repeatedly
        @(negedge clk);
        force dut.r_underrun_cnt = 16'hFFFD;
        @(negedge clk);
        release dut.r_underrun_cnt;
        #1;
        check("e_preload", 32'(underrun_cnt_o), 32'hFFFD);
        u0 = und_cycles;
        push({16'h0001, 16'h0002});
        s = fall_cnt + 1;
        enable = 1'b1;
        wait_fall(s + 40, "e_reach1");
        check("e_cnt_fffe", 32'(underrun_cnt_o), 32'hFFFE);
        wait_fall(s + 72, "e_reach2");
        check("e_cnt_ffff", 32'(underrun_cnt_o), 32'hFFFF);
        wait_fall(s + 104, "e_reach3");
        check("e_cnt_sat", 32'(underrun_cnt_o), 32'hFFFF);
        check("e_pulses", 32'(und_cycles - u0), 32'd3);
        check("e_L0", 32'(word_at(s + 1)), 32'h0001);
        enable = 1'b0;
        wait_idle("e_idle");
        check("e_cnt_final", 32'(underrun_cnt_o), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
